// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Synchronises and debounces N_BTN raw push-button / switch pins. Each channel
// has its own 2-flop synchroniser, a 4-state FSM (UP, WAIT_DN, DOWN, WAIT_UP)
// and a stability counter. A change of level is accepted only after
// DEBOUNCE_CYCLES consecutive identical synchronised samples.
//
// Optional feature (macro LONG_PRESS_EN):
//   When defined, the counter keeps running while a button is held. BTN_LONG
//   pulses once per press when the hold reaches LONG_CYCLES. A short release
//   glitch neither resets the hold count nor re-arms the pulse.
//   When undefined, BTN_LONG is tied to 0 and no long-press logic is built.
//
// Ports:
//   CLK          system clock (12 MHz)
//   RST          asynchronous, active-high reset
//   BTN_RAW      raw, asynchronous button pins
//   BTN_STATE    debounced level, 1 = pressed
//   BTN_PRESS    one-cycle pulse on accepted press
//   BTN_RELEASE  one-cycle pulse on accepted release
//   BTN_LONG     one-cycle long-press pulse (0 without LONG_PRESS_EN)
// -----------------------------------------------------------------------------
module button_debouncer #(
   parameter int N_BTN           = 4,
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int ACTIVE_LOW      = 1,
   parameter int LONG_CYCLES     = 12000000
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [N_BTN-1:0] BTN_RAW,
   output logic [N_BTN-1:0] BTN_STATE,
   output logic [N_BTN-1:0] BTN_PRESS,
   output logic [N_BTN-1:0] BTN_RELEASE,
   output logic [N_BTN-1:0] BTN_LONG
);

   localparam int MAX_CYC = (LONG_CYCLES > DEBOUNCE_CYCLES) ? LONG_CYCLES : DEBOUNCE_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);

   // Raw pin level that means "released"; the synchroniser resets to it.
   localparam logic REL_LEVEL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef LONG_PRESS_EN
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
   localparam logic [CW-1:0] LONG_MAX  = CW'(LONG_CYCLES);

   // Hold-count increment saturating at LONG_CYCLES, so LONG_LAST is passed
   // exactly once per press.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v >= LONG_MAX) ? LONG_MAX : v + CNT_ONE;
   endfunction
`endif

   typedef enum logic [1:0] {
      UP      = 2'd0,
      WAIT_DN = 2'd1,
      DOWN    = 2'd2,
      WAIT_UP = 2'd3
   } state_t;

   generate
      for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
         logic          sync1_reg;
         logic          sync2_reg;
         logic          p;
         state_t        state_reg, state_next;
         logic [CW-1:0] cnt_reg, cnt_next;
         logic          level_reg, level_next;
         logic          press_reg, press_next;
         logic          release_reg, release_next;

         // Two-flop synchroniser for the asynchronous pin.
         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               sync1_reg <= REL_LEVEL;
               sync2_reg <= REL_LEVEL;
            end else begin
               sync1_reg <= BTN_RAW[gi];
               sync2_reg <= sync1_reg;
            end
         end

         // Polarity-corrected sample: 1 = pressed.
         assign p = sync2_reg ^ REL_LEVEL;

`ifdef LONG_PRESS_EN
         // Hold count parked here while WAIT_UP reuses cnt for debouncing.
         // It keeps advancing so a glitch does not shift the long pulse.
         logic [CW-1:0] save_reg, save_next;
         logic          long_reg, long_next;
`endif

         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               state_reg   <= UP;
               cnt_reg     <= '0;
               level_reg   <= 1'b0;
               press_reg   <= 1'b0;
               release_reg <= 1'b0;
`ifdef LONG_PRESS_EN
               save_reg    <= '0;
               long_reg    <= 1'b0;
`endif
            end else begin
               state_reg   <= state_next;
               cnt_reg     <= cnt_next;
               level_reg   <= level_next;
               press_reg   <= press_next;
               release_reg <= release_next;
`ifdef LONG_PRESS_EN
               save_reg    <= save_next;
               long_reg    <= long_next;
`endif
            end
         end

         always_comb begin
            state_next   = state_reg;
            cnt_next     = cnt_reg;
            level_next   = level_reg;
            press_next   = 1'b0;
            release_next = 1'b0;
`ifdef LONG_PRESS_EN
            save_next    = save_reg;
            long_next    = 1'b0;
`endif
            case (state_reg)
               UP: begin
                  if (p) begin
                     state_next = WAIT_DN;
                     cnt_next   = CNT_ONE;
                  end else begin
                     cnt_next   = '0;
                  end
`ifdef LONG_PRESS_EN
                  save_next = '0;
`endif
               end

               WAIT_DN: begin
                  if (!p) begin
                     // Glitch: back to idle silently.
                     state_next = UP;
                     cnt_next   = '0;
                  end else if (cnt_reg == DB_LAST) begin
                     state_next = DOWN;
                     cnt_next   = '0;
                     level_next = 1'b1;
                     press_next = 1'b1;
                  end else begin
                     cnt_next   = cnt_reg + CNT_ONE;
                  end
               end

               DOWN: begin
`ifdef LONG_PRESS_EN
                  long_next = (cnt_reg == LONG_LAST);
                  if (!p) begin
                     state_next = WAIT_UP;
                     save_next  = sat_inc(cnt_reg);
                     cnt_next   = CNT_ONE;
                  end else begin
                     cnt_next   = sat_inc(cnt_reg);
                  end
`else
                  if (!p) begin
                     state_next = WAIT_UP;
                     cnt_next   = CNT_ONE;
                  end else begin
                     cnt_next   = '0;
                  end
`endif
               end

               WAIT_UP: begin
`ifdef LONG_PRESS_EN
                  save_next = sat_inc(save_reg);
                  long_next = (save_reg == LONG_LAST);
`endif
                  if (p) begin
                     // Glitch: button still held.
                     state_next = DOWN;
`ifdef LONG_PRESS_EN
                     cnt_next   = sat_inc(save_reg);
`else
                     cnt_next   = '0;
`endif
                  end else if (cnt_reg == DB_LAST) begin
                     state_next   = UP;
                     cnt_next     = '0;
                     level_next   = 1'b0;
                     release_next = 1'b1;
`ifdef LONG_PRESS_EN
                     long_next    = 1'b0;
`endif
                  end else begin
                     cnt_next     = cnt_reg + CNT_ONE;
                  end
               end

               default: begin
                  state_next = UP;
                  cnt_next   = '0;
                  level_next = 1'b0;
               end
            endcase
         end

         assign BTN_STATE[gi]   = level_reg;
         assign BTN_PRESS[gi]   = press_reg;
         assign BTN_RELEASE[gi] = release_reg;
`ifdef LONG_PRESS_EN
         assign BTN_LONG[gi]    = long_reg;
`else
         assign BTN_LONG[gi]    = 1'b0;
`endif
      end
   endgenerate

endmodule
